backward: RTL
=============

Name: backward

Overview:
- Error back-propagation stage of a neuron; the reverse-direction counterpart of the forward multiply-accumulate path.
- Accepts one error sample from the downstream layer.
- For each of N input connections in turn: fetches that connection's weight from weight memory, multiplies the error by the weight in Q-format fixed point, saturates the product to W bits, and sends it out on that connection's master port.
- Fans one input out to N outputs, where the forward path fans N inputs in to one.

Parameters:
- W, 16: data width in bits; signed two's complement.
- N, 2: number of back-propagated connections; must be ≥ 2.
- Q, 8: fractional bits of the fixed-point format; must satisfy 0 ≤ Q < W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- s_stb  in  1  error input strobe.
- s_dat  in  W  error value, signed Q-format.
- s_rdy  out  1  error input ready.
- m_rdy  in  N  per-connection output ready.
- m_stb  out  N  per-connection output strobe; one-hot or zero.
- m_dat  out  N*W  per-connection output data; every lane carries the same result register.
- d_stb  in  1  weight memory data strobe.
- d_dat  in  W  weight value, signed Q-format.
- d_rdy  out  1  weight memory data ready.
- a_rdy  in  1  weight address ready.
- a_stb  out  1  weight address strobe.
- a_dat  out  $clog2(N)  weight address, i.e. the connection index.

Behaviour:
- Handshake rules:
  - A transfer occurs on a rising clk edge where stb and rdy are both high.
  - Masters hold stb and dat stable until the transfer occurs.
  - No combinational path from any rdy input to any rdy output.
- Registers: state, idx ($clog2(N) bits), err (W), res (W).
- Reset (async, rst high):
  - state=IDLE, idx=0, err=0, res=0.
  - Combinational outputs: s_rdy=0 while rst high; m_stb=0, a_stb=0, d_rdy=0, m_dat=0, a_dat=0.
  - Reset mid-operation aborts the sequence immediately.
  - No partial outputs are completed after rst deasserts.
- FSM:
  - IDLE: s_rdy=1.
    - On s_stb: err<=s_dat, idx<=0, go to ADDR.
  - ADDR: a_stb=1, a_dat=idx.
    - On a_rdy: go to DATA.
  - DATA: d_rdy=1.
    - On d_stb: res<=sat((err*d_dat)>>>Q), go to OUT.
  - OUT: m_stb[idx]=1, all other m_stb bits 0.
    - On m_rdy[idx]: if idx==N-1, go to IDLE with idx<=0; else idx<=idx+1 and go to ADDR.
    - m_rdy bits other than idx are ignored.
- Arithmetic:
  - Signed W×W product, 2W bits wide.
  - Arithmetic shift right by Q; truncation toward −inf, no rounding.
  - Clamp to [−2^(W−1), 2^(W−1)−1].
- Outputs: s_rdy, a_stb, d_rdy and m_stb are decoded from state only. m_dat replicates res on every lane.
- Latency and throughput:
  - Minimum 3 cycles per connection with zero stalls.
  - A new error is accepted no earlier than 1 cycle after the last output transfer, so minimum 3N+1 cycles per error.
- Boundary conditions:
  - Stalls of any length on a_rdy, d_stb or m_rdy leave all held outputs stable.
  - s_stb while not in IDLE is not accepted; s_rdy=0.
  - d_stb arriving in ADDR is ignored, because d_rdy=0.
  - idx never exceeds N−1.

Test Plan:
- Basic (W=16, Q=8, N=2): error 0x0200; weights 0x0180 (addr 0) and 0xFF00 (addr 1); all rdy high → a_dat sequence 0,1; lane 0 receives 0x0300, lane 1 receives 0xFE00; 7 cycles from s_stb transfer to return to IDLE (s_rdy=1).
- Saturation: error 0x7FFF with weight 0x7FFF → 0x7FFF; error 0x8000 with weight 0x7FFF → 0x8000; error 0xFFFF with weight 0x0001 → 0xFFFF (truncation toward −inf).
- Backpressure: hold m_rdy[0]=0 for 5 cycles, hold a_rdy=0 for 3 cycles, delay d_stb by 4 cycles → m_stb, m_dat and a_dat are held stable throughout; the same results as the basic case arrive in order; s_rdy stays 0 until the final output transfer.
- Lane isolation: in OUT with idx=1, drive m_rdy=2'b01 → no transfer; m_stb stays 2'b10.
- Reset mid-operation: assert rst asynchronously while in DATA → all strobes and s_rdy drop within the same cycle; after release, s_rdy=1 and a fresh error (0x0100 with weights 0x0100, 0x0100) yields 0x0100 on both lanes.
- Back-to-back: s_stb held high with two queued errors → the second error is accepted exactly 1 cycle after lane N−1's transfer; no outputs are lost or duplicated.

Source files
------------

// File: rtl/backward_if.sv
// Bundle of the error-input, per-connection output and weight-memory handshakes of
// the back-propagation stage.
//   s_*  : error sample in        (s_stb/s_dat in, s_rdy out of the stage)
//   m_*  : per-connection outputs  (m_stb/m_dat out, m_rdy in)
//   a_*  : weight address out      (a_stb/a_dat out, a_rdy in)
//   d_*  : weight data in          (d_stb/d_dat in, d_rdy out)
// The slave modport is the stage itself; master is its environment.
interface backward_if #(
    parameter int unsigned W = 16,
    parameter int unsigned N = 2
);
    localparam int unsigned AW = $clog2(N);

    logic              s_stb;
    logic [W-1:0]      s_dat;
    logic              s_rdy;
    logic [N-1:0]      m_rdy;
    logic [N-1:0]      m_stb;
    logic [N*W-1:0]    m_dat;
    logic              d_stb;
    logic [W-1:0]      d_dat;
    logic              d_rdy;
    logic              a_rdy;
    logic              a_stb;
    logic [AW-1:0]     a_dat;

    modport slave (
        input  s_stb, s_dat, m_rdy, d_stb, d_dat, a_rdy,
        output s_rdy, m_stb, m_dat, d_rdy, a_stb, a_dat
    );

    modport master (
        output s_stb, s_dat, m_rdy, d_stb, d_dat, a_rdy,
        input  s_rdy, m_stb, m_dat, d_rdy, a_stb, a_dat
    );
endinterface

// File: rtl/backward.sv
// Error back-propagation stage of a neuron. Takes one error sample, then for each of
// the N connections fetches its weight, forms sat((err * weight) >>> Q) and offers the
// result on that connection's output lane.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : backward_if.slave carrying the s_*, m_*, a_* and d_* handshakes
module backward #(
    parameter int unsigned W = 16,
    parameter int unsigned N = 2,
    parameter int unsigned Q = 8
) (
    input logic        clk,
    input logic        rst,
    backward_if.slave  bus
);
    localparam int unsigned AW = $clog2(N);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StOut  = 2'd3;

    // Saturation bounds expressed at product width.
    localparam logic signed [2*W-1:0] ResMax = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] ResMin = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [W-1:0]  err_q, err_d;
    logic [W-1:0]  res_q, res_d;

    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] shifted;
    logic [W-1:0]          sat;

    // Multiply at full product width, arithmetic shift (floors toward -inf), clamp.
    always_comb begin
        prod    = $signed({{W{err_q[W-1]}}, err_q}) *
                  $signed({{W{bus.d_dat[W-1]}}, bus.d_dat});
        shifted = prod >>> Q;
        if (shifted > ResMax) begin
            sat = ResMax[W-1:0];
        end else if (shifted < ResMin) begin
            sat = ResMin[W-1:0];
        end else begin
            sat = shifted[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        res_d   = res_q;
        case (state_q)
            StIdle: begin
                if (bus.s_stb) begin
                    err_d   = bus.s_dat;
                    idx_d   = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (bus.a_rdy) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bus.d_stb) begin
                    res_d   = sat;
                    state_d = StOut;
                end
            end
            StOut: begin
                // Only the active lane's ready can complete the transfer.
                if (bus.m_rdy[idx_q]) begin
                    if (idx_q == AW'(N - 1)) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StAddr;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            err_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    // Outputs decode state only, so no ready input reaches a ready output.
    always_comb begin
        bus.s_rdy = (state_q == StIdle) && !rst;
        bus.a_stb = (state_q == StAddr);
        bus.a_dat = idx_q;
        bus.d_rdy = (state_q == StData);
        bus.m_stb = (state_q == StOut) ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;
        bus.m_dat = {N{res_q}};
    end
endmodule
